// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin arbiter sharing the async FIFO write port.
// Burst-based grants capped at MAX_BURST words, with per-requester word counters.
module fifo_wr_arb #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic              wr_clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic              req0,
   input  logic [DATA_W-1:0] d0,
   output logic              ack0,
   input  logic              req1,
   input  logic [DATA_W-1:0] d1,
   output logic              ack1,
   input  logic              full,
   output logic              wr,
   output logic [DATA_W-1:0] d_in,
   output logic [1:0]        grant,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] BEAT_MAX = 8'(MAX_BURST - 1);

   state_t     state;
   logic [7:0] beat;
   logic       last;

   logic own_id;
   logic own_req;
   logic oth_req;
   logic own_ack;
   logic burst_end;

   assign ack0 = (state == OWN0) & req0 & ~full & ~rst;
   assign ack1 = (state == OWN1) & req1 & ~full & ~rst;
   assign wr   = ack0 | ack1;
   assign d_in = ack0 ? d0 : (ack1 ? d1 : '0);
   assign busy = |grant;

   assign own_id    = (state == OWN1);
   assign own_req   = own_id ? req1 : req0;
   assign oth_req   = own_id ? req0 : req1;
   assign own_ack   = ack0 | ack1;
   // A stalled owner that withdraws its request still gives up the port.
   assign burst_end = (own_ack & (beat == BEAT_MAX)) | ~own_req;

   always_ff @(posedge wr_clk_in) begin
      if (rst) begin
         state <= IDLE;
         grant <= 2'b00;
         beat  <= 8'd0;
         last  <= 1'b1;
         cnt0  <= '0;
         cnt1  <= '0;
      end else begin
         if (ack0) cnt0 <= cnt0 + 1'b1;
         if (ack1) cnt1 <= cnt1 + 1'b1;
         unique case (state)
            IDLE: begin
               if (en & (req0 | req1)) begin
                  if (req0 & (~req1 | last)) begin
                     state <= OWN0;
                     grant <= 2'b01;
                  end else begin
                     state <= OWN1;
                     grant <= 2'b10;
                  end
               end
            end
            OWN0, OWN1: begin
               if (burst_end) begin
                  beat <= 8'd0;
                  last <= own_id;
                  if (en & oth_req) begin
                     state <= own_id ? OWN0 : OWN1;
                     grant <= own_id ? 2'b01 : 2'b10;
                  end else if (!(en & own_req)) begin
                     state <= IDLE;
                     grant <= 2'b00;
                  end
               end else if (own_ack) begin
                  beat <= beat + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized self-checking bench for fifo_wr_arb.
// Producers are word queues; a burst-budget reference model predicts every cycle.
module tb_fifo_wr_arb;

   localparam int DW  = 8;
   localparam int MB  = 4;
   localparam int CW  = 4;
   localparam int CMOD = 1 << CW;

   logic          clk = 1'b0;
   logic          rst, en, req0, req1, full;
   logic [DW-1:0] d0, d1;
   logic          ack0, ack1, wr, busy;
   logic [DW-1:0] d_in;
   logic [1:0]    grant;
   logic [CW-1:0] cnt0, cnt1;

   always #5 clk = ~clk;

   fifo_wr_arb #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
      .wr_clk_in(clk), .rst(rst), .en(en),
      .req0(req0), .d0(d0), .ack0(ack0),
      .req1(req1), .d1(d1), .ack1(ack1),
      .full(full), .wr(wr), .d_in(d_in),
      .grant(grant), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
   );

   int nvec = 0;
   int nerr = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   bit hold0, hold1, rst_v, en_v, full_v;

   // Reference model: owner id (-1 none), words taken in this burst.
   int m_own = -1;
   int m_taken = 0;
   int m_last = 1;
   int m_cnt0 = 0;
   int m_cnt1 = 0;
   bit m_known = 0;

   logic          s_ack0, s_ack1, s_wr, s_busy;
   logic [DW-1:0] s_d;
   logic [1:0]    s_grant;
   logic [CW-1:0] s_cnt0, s_cnt1;

   task automatic tick();
      bit e0, e1, r0, r1;
      logic [DW-1:0] ed;
      logic [1:0] eg;
      @(negedge clk);
      rst  = rst_v;
      en   = en_v;
      full = full_v;
      req0 = hold0 && q0.size() > 0;
      req1 = hold1 && q1.size() > 0;
      d0   = req0 ? q0[0] : DW'($urandom);
      d1   = req1 ? q1[0] : DW'($urandom);
      r0 = req0;
      r1 = req1;
      #1;
      e0 = !rst_v && m_own == 0 && r0 && !full_v;
      e1 = !rst_v && m_own == 1 && r1 && !full_v;
      ed = e0 ? d0 : (e1 ? d1 : '0);
      eg = (m_own == 0) ? 2'b01 : ((m_own == 1) ? 2'b10 : 2'b00);
      s_ack0 = ack0; s_ack1 = ack1; s_wr = wr; s_d = d_in;
      s_grant = grant; s_busy = busy; s_cnt0 = cnt0; s_cnt1 = cnt1;
      nvec++;
      if (ack0 !== e0) begin
         nerr++; $display("FAIL ack0 @%0t: got %b want %b", $time, ack0, e0);
      end
      nvec++;
      if (ack1 !== e1) begin
         nerr++; $display("FAIL ack1 @%0t: got %b want %b", $time, ack1, e1);
      end
      nvec++;
      if (wr !== (e0 | e1)) begin
         nerr++; $display("FAIL wr @%0t: got %b want %b", $time, wr, e0 | e1);
      end
      nvec++;
      if (d_in !== ed) begin
         nerr++; $display("FAIL d_in @%0t: got %h want %h", $time, d_in, ed);
      end
      if (m_known) begin
         nvec++;
         if (grant !== eg) begin
            nerr++; $display("FAIL grant @%0t: got %b want %b", $time, grant, eg);
         end
         nvec++;
         if (busy !== (eg != 2'b00)) begin
            nerr++; $display("FAIL busy @%0t: got %b want %b", $time, busy, eg != 2'b00);
         end
         nvec++;
         if (cnt0 !== CW'(m_cnt0) || cnt1 !== CW'(m_cnt1)) begin
            nerr++;
            $display("FAIL cnt @%0t: got %0d/%0d want %0d/%0d",
                     $time, cnt0, cnt1, m_cnt0, m_cnt1);
         end
      end
      nvec++;
      if ((ack0 & ack1) === 1'b1 || (wr & full) === 1'b1) begin
         nerr++; $display("FAIL invariant @%0t: ack0=%b ack1=%b wr=%b full=%b",
                          $time, ack0, ack1, wr, full);
      end
      @(posedge clk);
      if (rst_v) begin
         m_own = -1; m_taken = 0; m_last = 1;
         m_cnt0 = 0; m_cnt1 = 0; m_known = 1;
      end else begin
         if (e0) begin m_cnt0 = (m_cnt0 + 1) % CMOD; void'(q0.pop_front()); end
         if (e1) begin m_cnt1 = (m_cnt1 + 1) % CMOD; void'(q1.pop_front()); end
         if (m_own < 0) begin
            if (en_v && (r0 || r1))
               m_own = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
         end else begin
            int me;
            bit mine, other;
            me = m_own;
            mine  = me ? r1 : r0;
            other = me ? r0 : r1;
            if (e0 || e1) m_taken++;
            if (!mine || m_taken == MB) begin
               m_last = me;
               m_taken = 0;
               if (en_v && other) m_own = 1 - me;
               else if (en_v && mine) m_own = me;
               else m_own = -1;
            end
         end
      end
   endtask

   task automatic do_reset();
      q0.delete(); q1.delete();
      en_v = 1; full_v = 0; rst_v = 1;
      tick(); tick();
      rst_v = 0;
   endtask

   task automatic test_reset();
      hold0 = 0; hold1 = 0;
      do_reset();
      tick();
      nvec++;
      if (s_grant !== 2'b00 || s_wr !== 1'b0 || s_busy !== 1'b0 ||
          s_cnt0 !== '0 || s_cnt1 !== '0) begin
         nerr++;
         $display("FAIL reset_idle: grant=%b wr=%b busy=%b cnt=%0d/%0d want 00 0 0 0/0",
                  s_grant, s_wr, s_busy, s_cnt0, s_cnt1);
      end
   endtask

   task automatic test_stream();
      logic [DW-1:0] w[10];
      logic [DW-1:0] got[$];
      int first = -1;
      int lastk = -1;
      bit seq_ok;
      hold0 = 0; hold1 = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin w[i] = DW'($urandom); q0.push_back(w[i]); end
      hold0 = 1;
      for (int k = 0; k < 14; k++) begin
         tick();
         if (s_ack0) begin
            if (first < 0) first = k;
            lastk = k;
            got.push_back(s_d);
         end
      end
      nvec++;
      if (first != 1 || lastk != 10) begin
         nerr++; $display("FAIL stream_timing: acks %0d..%0d want 1..10", first, lastk);
      end
      seq_ok = (got.size() == 10);
      for (int i = 0; i < got.size() && i < 10; i++) if (got[i] !== w[i]) seq_ok = 0;
      nvec++;
      if (!seq_ok) begin
         nerr++; $display("FAIL stream_data: got %0d words, order mismatch or loss", got.size());
      end
      nvec++;
      if (s_cnt0 !== CW'(10)) begin
         nerr++; $display("FAIL stream_cnt0: got %0d want 10", s_cnt0);
      end
   endtask

   task automatic test_tie();
      int exp_own, diff;
      hold0 = 1; hold1 = 1;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom));
      end
      for (int k = 0; k < 25; k++) begin
         tick();
         if (k >= 1) begin
            exp_own = ((k - 1) / MB) % 2;
            nvec++;
            if (s_grant !== (exp_own ? 2'b10 : 2'b01) ||
                (exp_own ? s_ack1 : s_ack0) !== 1'b1) begin
               nerr++; $display("FAIL tie_k%0d: grant=%b ack0=%b ack1=%b want owner %0d",
                                k, s_grant, s_ack0, s_ack1, exp_own);
            end
            diff = int'(s_cnt0) - int'(s_cnt1);
            nvec++;
            if (diff > MB || diff < -MB) begin
               nerr++; $display("FAIL tie_balance: cnt0=%0d cnt1=%0d", s_cnt0, s_cnt1);
            end
         end
      end
   endtask

   task automatic test_full();
      logic [DW-1:0] w[10];
      logic [DW-1:0] got[$];
      bit seq_ok;
      hold0 = 1; hold1 = 1;
      do_reset();
      for (int i = 0; i < 10; i++) begin w[i] = DW'($urandom); q0.push_back(w[i]); end
      for (int i = 0; i < 4; i++) q1.push_back(DW'($urandom));
      for (int k = 0; k < 22; k++) begin
         full_v = (k >= 3 && k <= 7);
         tick();
         if (s_ack0) got.push_back(s_d);
         if (k >= 3 && k <= 7) begin
            nvec++;
            if (s_wr !== 1'b0 || s_grant !== 2'b01) begin
               nerr++; $display("FAIL full_stall_k%0d: wr=%b grant=%b want 0 01", k, s_wr, s_grant);
            end
         end
         if (k == 8) begin
            nvec++;
            if (s_ack0 !== 1'b1 || s_d !== w[2]) begin
               nerr++; $display("FAIL full_resume: ack0=%b d_in=%h want 1 %h", s_ack0, s_d, w[2]);
            end
         end
         if (k == 10) begin
            nvec++;
            if (s_grant !== 2'b10) begin
               nerr++; $display("FAIL full_beat_hold: grant=%b want 10", s_grant);
            end
         end
      end
      full_v = 0;
      seq_ok = (got.size() == 10);
      for (int i = 0; i < got.size() && i < 10; i++) if (got[i] !== w[i]) seq_ok = 0;
      nvec++;
      if (!seq_ok) begin
         nerr++; $display("FAIL full_data: got %0d words, want 10 in order", got.size());
      end
   endtask

   task automatic test_release_en();
      logic [DW-1:0] w[6];
      hold0 = 0; hold1 = 1;
      do_reset();
      for (int i = 0; i < 6; i++) begin w[i] = DW'($urandom); q0.push_back(w[i]); end
      q1.push_back(DW'($urandom)); q1.push_back(DW'($urandom));
      for (int k = 0; k < 14; k++) begin
         if (k == 1) hold0 = 1;
         if (k == 4) en_v = 0;
         if (k == 11) en_v = 1;
         tick();
         if (k == 3) begin
            nvec++;
            if (s_grant !== 2'b10 || s_ack1 !== 1'b0) begin
               nerr++; $display("FAIL release_drop: grant=%b ack1=%b want 10 0", s_grant, s_ack1);
            end
         end
         if (k >= 4 && k <= 7) begin
            nvec++;
            if (s_grant !== 2'b01 || s_ack0 !== 1'b1) begin
               nerr++; $display("FAIL en_burst_k%0d: grant=%b ack0=%b want 01 1", k, s_grant, s_ack0);
            end
         end
         if (k >= 8 && k <= 11) begin
            nvec++;
            if (s_grant !== 2'b00 || s_wr !== 1'b0) begin
               nerr++; $display("FAIL en_gate_k%0d: grant=%b wr=%b want 00 0", k, s_grant, s_wr);
            end
         end
         if (k == 12) begin
            nvec++;
            if (s_grant !== 2'b01 || s_d !== w[4]) begin
               nerr++; $display("FAIL en_resume: grant=%b d_in=%h want 01 %h", s_grant, s_d, w[4]);
            end
         end
      end
   endtask

   task automatic test_wrap_reset();
      hold0 = 0; hold1 = 1;
      do_reset();
      for (int i = 0; i < 17; i++) q1.push_back(DW'($urandom));
      for (int k = 0; k < 19; k++) tick();
      nvec++;
      if (s_cnt1 !== CW'(1)) begin
         nerr++; $display("FAIL cnt_wrap: cnt1=%0d want 1", s_cnt1);
      end
      for (int i = 0; i < 6; i++) begin
         q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom));
      end
      tick(); tick(); tick();
      rst_v = 1;
      tick();
      nvec++;
      if (s_ack1 !== 1'b0 || s_wr !== 1'b0) begin
         nerr++; $display("FAIL rst_noack: ack1=%b wr=%b want 0 0", s_ack1, s_wr);
      end
      rst_v = 0; hold0 = 1;
      tick();
      nvec++;
      if (s_grant !== 2'b00 || s_cnt0 !== '0 || s_cnt1 !== '0) begin
         nerr++; $display("FAIL rst_mid: grant=%b cnt=%0d/%0d want 00 0/0", s_grant, s_cnt0, s_cnt1);
      end
      tick();
      nvec++;
      if (s_grant !== 2'b01 || s_ack0 !== 1'b1) begin
         nerr++; $display("FAIL rst_tie: grant=%b ack0=%b want 01 1", s_grant, s_ack0);
      end
   endtask

   task automatic test_random();
      int budget;
      hold0 = 1; hold1 = 1;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         hold0  = ($urandom % 4) != 0;
         hold1  = ($urandom % 4) != 0;
         full_v = ($urandom % 4) == 0;
         en_v   = ($urandom % 8) != 0;
         rst_v  = ($urandom % 100) == 0;
         if (q0.size() < 3 && $urandom % 2) q0.push_back(DW'($urandom));
         if (q1.size() < 3 && $urandom % 2) q1.push_back(DW'($urandom));
         tick();
      end
      hold0 = 1; hold1 = 1; full_v = 0; en_v = 1; rst_v = 0;
      budget = 0;
      while ((q0.size() > 0 || q1.size() > 0) && budget < 100) begin
         tick();
         budget++;
      end
      nvec++;
      if (q0.size() > 0 || q1.size() > 0) begin
         nerr++; $display("FAIL random_drain: %0d/%0d words left after timeout", q0.size(), q1.size());
      end
   endtask

   initial begin
      rst = 1; en = 0; req0 = 0; req1 = 0; full = 0; d0 = '0; d1 = '0;
      hold0 = 0; hold1 = 0; rst_v = 1; en_v = 1; full_v = 0;
      test_reset();
      test_stream();
      test_tie();
      test_full();
      test_release_en();
      test_wrap_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Two-requester round-robin arbiter that shares the single write port (wr, d_in, full) of the async FIFO between two producers.
- Sits entirely in the FIFO write-clock domain and drives the FIFO's wr/d_in directly.
- Grants are burst-based, with a bounded burst length for fairness.
- Keeps per-requester accepted-word counters for bench scoreboarding.

Parameters:
- DATA_W, 8, data width; matches FIFO d_in.
- MAX_BURST, 4, maximum words per grant before the arbiter must re-arbitrate (range 1..255).
- CNT_W, 16, width of the per-requester accepted-word counters.

Ports:
- wr_clk_in  in  1  write-domain clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  arbitration enable; low blocks new grants.
- req0  in  1  requester 0 has a word on d0.
- d0  in  DATA_W  requester 0 data.
- ack0  out  1  word on d0 accepted this cycle (combinational).
- req1  in  1  requester 1 has a word on d1.
- d1  in  DATA_W  requester 1 data.
- ack1  out  1  word on d1 accepted this cycle (combinational).
- full  in  1  FIFO full flag (write domain).
- wr  out  1  FIFO write strobe (combinational, = ack0|ack1).
- d_in  out  DATA_W  FIFO write data (owner's data while wr=1, else 0).
- grant  out  2  one-hot current owner (registered; 00 = none).
- busy  out  1  grant != 00.
- cnt0  out  CNT_W  words accepted from requester 0.
- cnt1  out  CNT_W  words accepted from requester 1.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, grant=00, beat=0, last=1 (so requester 0 wins the first tie), cnt0=cnt1=0.
  - ack0, ack1 and wr are 0 during any cycle with rst=1.
- Handshake (valid/ready):
  - A producer holds reqX and dX stable until it sees ackX=1 at a posedge, then may present the next word.
  - A word transfers on a posedge where ackX=1.
  - ackX = (state==OWNX) & reqX & ~full & ~rst.
  - Zero latency: wr and d_in reflect the acked word in the same cycle.
- IDLE:
  - No acks.
  - If en & (req0|req1): next state = OWN of the sole requester; on a tie, the requester != last.
  - One-cycle grant latency from req to first possible ack.
- OWNX:
  - beat increments on each ackX.
  - Burst ends when either:
    - ackX & beat==MAX_BURST-1, or
    - ~reqX (sampled at the posedge).
  - On burst end: beat<=0, last<=X, then:
    - if en & other req: next state = OWN other, with no idle bubble;
    - else if en & reqX (max reached): stay in OWNX with a fresh burst;
    - else: IDLE.
- full=1 in OWNX: no ack, beat and state hold. reqX dropping while stalled still ends the burst.
- en=0 mid-burst: the current burst runs to its normal end, then the arbiter goes to IDLE.
- cntX increments by 1 on each ackX and wraps modulo 2^CNT_W.
- Invariants:
  - ack0 & ack1 is never 1.
  - wr=1 is never asserted while full=1.
  - No word is lost or duplicated.
- Reset mid-burst: returns to the reset state at that edge. The in-flight word is not acked; the producer must re-present it.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req0=req1=0 -> grant=00, wr=0, cnt0=cnt1=0, busy=0.
- Single requester streaming: req0 held with 10 words, en=1, full=0 ->
  - first ack0 in cycle 2;
  - acks in bursts of 4 with no bubble between self-renewed bursts;
  - cnt0=10, d_in sequence matches d0 sequence.
- Tie fairness: req0=req1=1 continuously with MAX_BURST=4 ->
  - grant alternates 01,10,01,… every 4 acks, requester 0 first;
  - no idle cycle between owners;
  - cnt0 and cnt1 differ by at most 4.
- Full backpressure: owner streaming, full forced high for 5 cycles mid-burst ->
  - wr=0 and beat frozen for those 5 cycles;
  - resumes on the exact next word with no loss or duplication.
- Early release and en gating:
  - req1 drops after 2 words -> grant passes to req0 next cycle.
  - en=0 mid-burst -> burst completes, then grant=00 until en=1.
- Counter wrap and reset mid-burst: CNT_W=4 with 17 words from requester 1 -> cnt1=1. Then assert rst during an active burst -> grant=00, counters 0, next grant goes to requester 0 on a tie.
